m10_pll_top: RTL and testbench

Clock-generation block for the MAX10 LTPI link. It produces a gated copy of the reference clock and two integer-divided, phase-aligned clocks, and raises `locked` once its lock counter expires. The interface follows the ALTPLL port set, so the block can stand in for the vendor PLL in simulation and in lightweight builds. Downstream SDR/LVDS logic uses `locked` as its release-from-reset qualifier.

---
 rtl/m10_pll_top.sv | 141 ++++++++++++++
 tb/tb_m10_pll_top.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/m10_pll_top.sv
// -----------------------------------------------------------------------------
// m10_pll_top
//   Behavioural stand-in for the ALTPLL used on the MAX10 LTPI link. It
//   produces a gated copy of the reference clock plus two even-integer divided
//   clocks that are phase aligned to it. It raises `locked` after a fixed
//   number of reference edges. Downstream SDR/LVDS logic holds itself in reset
//   until `locked` is high.
//
// Parameters
//   LOCK_CYCLES : inclk0 rising edges after reset release until lock (>= 1)
//   DIV_C1      : divisor for c1 (even, >= 2)
//   DIV_C2      : divisor for c2 (even, >= 2)
//
// Ports
//   inclk0 : in  reference clock, the only clock in the block
//   areset : in  asynchronous active-high reset
//   c0     : out inclk0 gated by the lock enable
//   c1     : out inclk0 / DIV_C1, 50% duty
//   c2     : out inclk0 / DIV_C2, 50% duty
//   locked : out lock indication, sticky until the next reset
// -----------------------------------------------------------------------------

// Divide-by-DIV clock generator. It counts only once `locked_i` was already
// high before the edge, so every divider starts on the same reference edge.
module m10_pll_div #(
    parameter int DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic locked_i,
    output logic clk_o
);
    localparam int            DW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] HALF = DW'(DIV / 2);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    always_comb begin
        cnt_d = '0;
        out_d = 1'b0;
        if (locked_i) begin
            // High while cnt is in the lower half, so the first post-lock
            // edge (cnt = 0) is a rising edge on the output.
            out_d = (cnt_q < HALF);
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign clk_o = out_q;
endmodule

module m10_pll_top #(
    parameter int LOCK_CYCLES = 16,
    parameter int DIV_C1      = 2,
    parameter int DIV_C2      = 4
) (
    input  logic inclk0,
    input  logic areset,
    output logic c0,
    output logic c1,
    output logic c2,
    output logic locked
);
    // Elaboration-time parameter guards.
    if (LOCK_CYCLES < 1) begin : g_bad_lock
        $error("m10_pll_top: LOCK_CYCLES must be >= 1");
    end
    if ((DIV_C1 < 2) || ((DIV_C1 % 2) != 0)) begin : g_bad_div_c1
        $error("m10_pll_top: DIV_C1 must be even and >= 2");
    end
    if ((DIV_C2 < 2) || ((DIV_C2 % 2) != 0)) begin : g_bad_div_c2
        $error("m10_pll_top: DIV_C2 must be even and >= 2");
    end

    localparam int            LW       = (LOCK_CYCLES >= 1) ? $clog2(LOCK_CYCLES + 1) : 1;
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          locked_q, locked_d;
    logic          c0_en_q;

    // Lock counter: counts reference edges after release and freezes at lock.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (!locked_q) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
            locked_d   = (lock_cnt_d == LOCK_MAX);
        end
    end

    always_ff @(posedge inclk0 or posedge areset) begin
        if (areset) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    // The c0 enable changes only while inclk0 is low. This makes the AND gate
    // below glitch-free. The first full c0 pulse starts on the reference edge
    // after the one that set locked.
    always_ff @(negedge inclk0 or posedge areset) begin
        if (areset) begin
            c0_en_q <= 1'b0;
        end else begin
            c0_en_q <= locked_q;
        end
    end

    assign c0     = inclk0 & c0_en_q;
    assign locked = locked_q;

    m10_pll_div #(.DIV(DIV_C1)) u_div_c1 (
        .clk_i    (inclk0),
        .rst_i    (areset),
        .locked_i (locked_q),
        .clk_o    (c1)
    );

    m10_pll_div #(.DIV(DIV_C2)) u_div_c2 (
        .clk_i    (inclk0),
        .rst_i    (areset),
        .locked_i (locked_q),
        .clk_o    (c2)
    );
endmodule

// File: tb/tb_m10_pll_top.sv
// -----------------------------------------------------------------------------
// tb_m10_pll_top
//   Drives two instances from one 100 MHz reference and one reset: dut_a uses
//   the default parameters (16/2/4) and dut_b uses the sweep set (1/4/8).
//   Expected outputs come from a closed-form model indexed by the number of
//   reference rising edges since reset release.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_m10_pll_top;
    localparam int LA = 16, D1A = 2, D2A = 4;
    localparam int LB = 1,  D1B = 4, D2B = 8;

    logic inclk0;
    logic areset;
    logic c0_a, c1_a, c2_a, locked_a;
    logic c0_b, c1_b, c2_b, locked_b;

    int vectors    = 0;
    int miscompares = 0;

    // ---------------- clock / reset ----------------
    initial inclk0 = 1'b0;
    always #5 inclk0 = ~inclk0;

    m10_pll_top #(.LOCK_CYCLES(LA), .DIV_C1(D1A), .DIV_C2(D2A)) dut_a (
        .inclk0 (inclk0),
        .areset (areset),
        .c0     (c0_a),
        .c1     (c1_a),
        .c2     (c2_a),
        .locked (locked_a)
    );

    m10_pll_top #(.LOCK_CYCLES(LB), .DIV_C1(D1B), .DIV_C2(D2B)) dut_b (
        .inclk0 (inclk0),
        .areset (areset),
        .c0     (c0_b),
        .c1     (c1_b),
        .c2     (c2_b),
        .locked (locked_b)
    );

    // ---------------- reference model ----------------
    // k = rising edges since release (1-based). Lock at edge l. A divided
    // clock first goes high at edge l+1 and repeats every d edges. It stays
    // high for d/2 of them.
    function automatic logic m_locked(input int k, input int l);
        return (k >= l);
    endfunction

    function automatic logic m_div(input int k, input int l, input int d);
        if (k <= l) return 1'b0;
        return (((k - l - 1) % d) < (d / 2));
    endfunction

    // c0 while inclk0 is high after edge k.
    function automatic logic m_c0_high(input int k, input int l);
        return (k >= l + 1);
    endfunction

    // ---------------- driver tasks ----------------
    // Release reset during the low phase, so the next rising edge is edge 1.
    task automatic release_reset();
        @(negedge inclk0);
        #($urandom_range(1, 3));
        areset = 1'b0;
    endtask

    // Run n edges after release and compare every output at both clock phases.
    task automatic run_edges(input int n, input string tag);
        for (int k = 1; k <= n; k++) begin
            @(posedge inclk0);
            #1;
            vectors++;
            if (locked_a !== m_locked(k, LA) || c1_a !== m_div(k, LA, D1A) ||
                c2_a !== m_div(k, LA, D2A) || c0_a !== m_c0_high(k, LA)) begin
                miscompares++;
                $display("FAIL %s dut_a rise k=%0d got c0/c1/c2/lk=%b%b%b%b exp %b%b%b%b", tag, k,
                         c0_a, c1_a, c2_a, locked_a, m_c0_high(k, LA), m_div(k, LA, D1A),
                         m_div(k, LA, D2A), m_locked(k, LA));
            end
            vectors++;
            if (locked_b !== m_locked(k, LB) || c1_b !== m_div(k, LB, D1B) ||
                c2_b !== m_div(k, LB, D2B) || c0_b !== m_c0_high(k, LB)) begin
                miscompares++;
                $display("FAIL %s dut_b rise k=%0d got c0/c1/c2/lk=%b%b%b%b exp %b%b%b%b", tag, k,
                         c0_b, c1_b, c2_b, locked_b, m_c0_high(k, LB), m_div(k, LB, D1B),
                         m_div(k, LB, D2B), m_locked(k, LB));
            end
            @(negedge inclk0);
            #1;
            // Low phase: c0 must be low. c1/c2/locked must not move off a rising edge.
            vectors++;
            if (c0_a !== 1'b0 || c1_a !== m_div(k, LA, D1A) || c2_a !== m_div(k, LA, D2A) ||
                locked_a !== m_locked(k, LA)) begin
                miscompares++;
                $display("FAIL %s dut_a fall k=%0d got c0/c1/c2/lk=%b%b%b%b", tag, k,
                         c0_a, c1_a, c2_a, locked_a);
            end
            vectors++;
            if (c0_b !== 1'b0 || c1_b !== m_div(k, LB, D1B) || c2_b !== m_div(k, LB, D2B) ||
                locked_b !== m_locked(k, LB)) begin
                miscompares++;
                $display("FAIL %s dut_b fall k=%0d got c0/c1/c2/lk=%b%b%b%b", tag, k,
                         c0_b, c1_b, c2_b, locked_b);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        areset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge inclk0);
            #1;
            vectors++;
            if ({c0_a, c1_a, c2_a, locked_a, c0_b, c1_b, c2_b, locked_b} !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_hold cycle=%0d got %b exp 00000000", i,
                         {c0_a, c1_a, c2_a, locked_a, c0_b, c1_b, c2_b, locked_b});
            end
        end
    endtask

    task automatic test_lock_timing();
        release_reset();
        // Lock, first output edges and 100+ cycles of c1/c2 alignment.
        run_edges(LA + 110, "lock_freq_align");
    endtask

    // Assert reset during the high phase while locked. Outputs must drop before
    // the next edge. Then hold, release and check the full relock sequence.
    task automatic test_mid_reset(input int offset, input int hold, input int run_len);
        @(posedge inclk0);
        #(offset);
        areset = 1'b1;
        #1;
        vectors++;
        if ({c0_a, c1_a, c2_a, locked_a, c0_b, c1_b, c2_b, locked_b} !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset_async off=%0d got %b exp 00000000", offset,
                     {c0_a, c1_a, c2_a, locked_a, c0_b, c1_b, c2_b, locked_b});
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge inclk0);
            #1;
            vectors++;
            if ({c0_a, c1_a, c2_a, locked_a, c0_b, c1_b, c2_b, locked_b} !== 8'h00) begin
                miscompares++;
                $display("FAIL mid_reset_hold i=%0d got %b exp 00000000", i,
                         {c0_a, c1_a, c2_a, locked_a, c0_b, c1_b, c2_b, locked_b});
            end
        end
        release_reset();
        run_edges(run_len, "relock");
    endtask

    task automatic test_random_resets();
        // Some runs end before lock, so reset also hits a partially counted lock.
        for (int it = 0; it < 8; it++) begin
            test_mid_reset($urandom_range(1, 4), $urandom_range(1, 6), $urandom_range(1, 60));
        end
    endtask

    initial begin
        test_reset();
        test_lock_timing();
        test_mid_reset(3, 3, LA + 20);
        test_random_resets();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
